silencer_settings_reader: RTL

- Consumer side of the host-written controller register BRAM.
- Polls the CTL_FLAG register and detects a 0->1 transition of CTL_FLAG_SILENCER_SET_BIT.
- On that edge, reads the five silencer registers (0x40-0x44) over a read-only BRAM port and commits them atomically to the silencer datapath with a one-cycle UPDATE strobe.
- Sits between the controller BRAM read port and the silencer.

---
 rtl/silencer_settings_reader_pkg.sv | 56 +++++
 rtl/ctl_bram_read_pipe.sv | 67 ++++++
 rtl/silencer_settings_reader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/silencer_settings_reader_pkg.sv
// Shared definitions for the controller-BRAM settings readers.
//   - Controller register addresses and the CTL_FLAG bit that requests a
//     silencer settings load.
//   - Silencer mode encodings and the power-on settings.
//   - silencer_settings_t: one complete silencer settings set, used for both
//     the shadow copy being assembled and the committed output copy.
//   - Read-tag encodings used with ctl_bram_read_pipe and the reader FSM states.
package silencer_settings_reader_pkg;

    localparam logic [7:0] ADDR_CTL_FLAG                              = 8'h00;
    localparam logic [7:0] ADDR_SILENCER_MODE                         = 8'h40;
    localparam logic [7:0] ADDR_SILENCER_UPDATE_RATE_INTENSITY        = 8'h41;
    localparam logic [7:0] ADDR_SILENCER_UPDATE_RATE_PHASE            = 8'h42;
    localparam logic [7:0] ADDR_SILENCER_COMPLETION_STEPS_INTENSITY   = 8'h43;
    localparam logic [7:0] ADDR_SILENCER_COMPLETION_STEPS_PHASE       = 8'h44;

    localparam int CTL_FLAG_SILENCER_SET_BIT = 2;

    localparam logic SILNCER_MODE_FIXED_COMPLETION_STEPS = 1'b0;
    localparam logic SILNCER_MODE_FIXED_UPDATE_RATE      = 1'b1;

    localparam logic [15:0] DEFAULT_UPDATE_RATE_INTENSITY      = 16'd256;
    localparam logic [15:0] DEFAULT_UPDATE_RATE_PHASE          = 16'd256;
    localparam logic [15:0] DEFAULT_COMPLETION_STEPS_INTENSITY = 16'd10;
    localparam logic [15:0] DEFAULT_COMPLETION_STEPS_PHASE     = 16'd40;

    // Read tags: 0..4 are the silencer words in address order, 5 is the flag poll.
    localparam int          TAG_W         = 3;
    localparam logic [2:0]  TAG_LAST_WORD = 3'd4;
    localparam logic [2:0]  TAG_CTL_FLAG  = 3'd5;

    typedef struct packed {
        logic        mode;
        logic [15:0] update_rate_intensity;
        logic [15:0] update_rate_phase;
        logic [15:0] completion_steps_intensity;
        logic [15:0] completion_steps_phase;
    } silencer_settings_t;

    localparam silencer_settings_t SILENCER_SETTINGS_RESET = '{
        mode:                       SILNCER_MODE_FIXED_COMPLETION_STEPS,
        update_rate_intensity:      DEFAULT_UPDATE_RATE_INTENSITY,
        update_rate_phase:          DEFAULT_UPDATE_RATE_PHASE,
        completion_steps_intensity: DEFAULT_COMPLETION_STEPS_INTENSITY,
        completion_steps_phase:     DEFAULT_COMPLETION_STEPS_PHASE
    };

    typedef enum logic [2:0] {
        POLL_ISSUE,
        POLL_WAIT,
        READ,
        DRAIN,
        COMMIT
    } state_t;

endpackage

// File: rtl/ctl_bram_read_pipe.sv
// Read-issue pipe for a fixed-latency, read-only controller BRAM port.
// A request presented on req_i/addr_i/tag_i goes straight to the BRAM in the
// same cycle; RD_LATENCY cycles later the returned word appears on rdata_o
// with rvalid_o high and the request's tag on rtag_o. Requests may be issued
// back to back, one per cycle, without stalling.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i             issue a read this cycle
//   addr_i, tag_i     word address and caller tag for the read
//   bram_en_o         BRAM read enable (equals req_i)
//   bram_addr_o       BRAM address; holds the last issued address when idle
//   bram_dout_i       BRAM read data
//   rvalid_o, rtag_o  returning word is valid this cycle / its tag
//   rdata_o           returning word
module ctl_bram_read_pipe #(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [DATA_W-1:0] bram_dout_i,
    output logic              rvalid_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [ADDR_W-1:0]     addr_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]      tag_q [RD_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            vld_q  <= '0;
        end else begin
            if (req_i) begin
                addr_q <= addr_i;
            end
            vld_q[0] <= req_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Tags ride alongside the valid bits; only the valid bits need a reset.
    always_ff @(posedge clk_i) begin
        tag_q[0] <= tag_i;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign bram_en_o   = req_i;
    assign bram_addr_o = req_i ? addr_i : addr_q;
    assign rvalid_o    = vld_q[RD_LATENCY-1];
    assign rtag_o      = tag_q[RD_LATENCY-1];
    assign rdata_o     = bram_dout_i;

endmodule

// File: rtl/silencer_settings_reader.sv
// Silencer settings reader: consumer side of the host-written controller BRAM.
// Polls CTL_FLAG and, on a 0->1 transition of the silencer-set bit, reads the
// five silencer registers (0x40-0x44) and commits them to the silencer as one
// atomic set with a one-cycle UPDATE strobe.
// Optional feature (macro SILENCER_SETTINGS_CHECK_EN): a set containing any
// zero 16-bit field is rejected (outputs kept, no UPDATE, sticky ERR); a valid
// commit clears ERR. Without the macro every set is committed and ERR is 0.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   BRAM_EN, BRAM_ADDR, BRAM_DOUT controller BRAM read port
//   MODE, UPDATE_RATE_*, COMPLETION_STEPS_*  committed silencer settings
//   UPDATE                        settings changed this cycle
//   BUSY                          a load is in progress
//   ERR                           sticky invalid-settings flag
module silencer_settings_reader
    import silencer_settings_reader_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        BRAM_EN,
    output logic [7:0]  BRAM_ADDR,
    input  logic [15:0] BRAM_DOUT,
    output logic        MODE,
    output logic [15:0] UPDATE_RATE_INTENSITY,
    output logic [15:0] UPDATE_RATE_PHASE,
    output logic [15:0] COMPLETION_STEPS_INTENSITY,
    output logic [15:0] COMPLETION_STEPS_PHASE,
    output logic        UPDATE,
    output logic        BUSY,
    output logic        ERR
);

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   idx_q, idx_d;
    logic               prev_q, prev_d;
    silencer_settings_t shadow_q;
    silencer_settings_t out_q;
    silencer_settings_t settings_vis;

    logic               fsm_req;
    logic [7:0]         req_addr;
    logic [TAG_W-1:0]   req_tag;
    logic               commit;
    logic               commit_ok;
    logic               rvalid;
    logic [TAG_W-1:0]   rtag;
    logic [15:0]        rdata;

    ctl_bram_read_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .ADDR_W     (8),
        .DATA_W     (16),
        .TAG_W      (TAG_W)
    ) u_read_pipe (
        .clk_i       (CLK),
        .rst_i       (RST),
        // Keep the port quiet while reset is held.
        .req_i       (fsm_req & ~RST),
        .addr_i      (req_addr),
        .tag_i       (req_tag),
        .bram_en_o   (BRAM_EN),
        .bram_addr_o (BRAM_ADDR),
        .bram_dout_i (BRAM_DOUT),
        .rvalid_o    (rvalid),
        .rtag_o      (rtag),
        .rdata_o     (rdata)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        prev_d   = prev_q;
        fsm_req  = 1'b0;
        req_addr = ADDR_CTL_FLAG;
        req_tag  = TAG_CTL_FLAG;
        commit   = 1'b0;
        case (state_q)
            POLL_ISSUE: begin
                fsm_req = 1'b1;
                state_d = POLL_WAIT;
            end
            POLL_WAIT: begin
                idx_d = '0;
                if (rvalid && rtag == TAG_CTL_FLAG) begin
                    prev_d = rdata[CTL_FLAG_SILENCER_SET_BIT];
                    if (rdata[CTL_FLAG_SILENCER_SET_BIT] && !prev_q) begin
                        state_d = READ;
                    end else begin
                        state_d = POLL_ISSUE;
                    end
                end
            end
            READ: begin
                fsm_req  = 1'b1;
                req_addr = ADDR_SILENCER_MODE + {5'b0, idx_q};
                req_tag  = idx_q;
                idx_d    = idx_q + 3'd1;
                if (idx_q == TAG_LAST_WORD) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Words keep landing in the shadow; the last one closes the set.
                if (rvalid && rtag == TAG_LAST_WORD) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = POLL_ISSUE;
            end
            default: state_d = POLL_ISSUE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= POLL_ISSUE;
            idx_q   <= '0;
            prev_q  <= 1'b0;
            out_q   <= SILENCER_SETTINGS_RESET;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            if (commit_ok) begin
                out_q <= shadow_q;
            end
        end
    end

    // Shadow capture is tag-addressed so early returns during READ land correctly.
    always_ff @(posedge CLK) begin
        if (rvalid) begin
            case (rtag)
                3'd0: shadow_q.mode                       <= rdata[0];
                3'd1: shadow_q.update_rate_intensity      <= rdata;
                3'd2: shadow_q.update_rate_phase          <= rdata;
                3'd3: shadow_q.completion_steps_intensity <= rdata;
                3'd4: shadow_q.completion_steps_phase     <= rdata;
                default: ;
            endcase
        end
    end

`ifdef SILENCER_SETTINGS_CHECK_EN
    function automatic logic settings_valid(input silencer_settings_t s);
        return (s.update_rate_intensity      != 16'd0) &&
               (s.update_rate_phase          != 16'd0) &&
               (s.completion_steps_intensity != 16'd0) &&
               (s.completion_steps_phase     != 16'd0);
    endfunction

    logic err_q;

    assign commit_ok = commit && settings_valid(shadow_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= !settings_valid(shadow_q);
        end
    end

    assign ERR = err_q;
`else
    assign commit_ok = commit;
    assign ERR       = 1'b0;
`endif

    // The committed set is visible in the UPDATE cycle itself; out_q holds it afterwards.
    assign settings_vis = commit_ok ? shadow_q : out_q;

    assign MODE                       = settings_vis.mode;
    assign UPDATE_RATE_INTENSITY      = settings_vis.update_rate_intensity;
    assign UPDATE_RATE_PHASE          = settings_vis.update_rate_phase;
    assign COMPLETION_STEPS_INTENSITY = settings_vis.completion_steps_intensity;
    assign COMPLETION_STEPS_PHASE     = settings_vis.completion_steps_phase;
    assign UPDATE                     = commit_ok;
    assign BUSY                       = (state_q == READ) || (state_q == DRAIN) || (state_q == COMMIT);

endmodule
